cplx_alu_seq: RTL

Sequential, parametrised complex-number arithmetic unit. It computes the sum, difference, product or quotient of two signed complex operands A = re1 + j·im1 and B = re2 + j·im2. Operands enter through a valid/ready input handshake and results leave through a valid/ready output handshake. It is the clocked successor of the team's combinational complex unit: signed, width-generic, with a multi-cycle iterative divider and divide-by-zero detection.

---
 rtl/cplx_alu_seq.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/cplx_alu_seq.sv
// Sequential complex ALU: A+B, A-B, A*B, A/B on signed W-bit complex operands.
// Ports: clk, rst_n (async, active low); in_valid/in_ready + re1, im1, re2, im2, itask
//        (0 SUM, 1 SUB, 2 MUL, 3 DIV) on the input side; out_valid/out_ready + out_re,
//        out_im (signed OW bits) and dbz (divide-by-zero, qualified by out_valid) on the output side.
module cplx_alu_seq #(
    parameter int W  = 16,
    parameter int OW = 2*W+2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  re1,
    input  logic signed [W-1:0]  im1,
    input  logic signed [W-1:0]  re2,
    input  logic signed [W-1:0]  im2,
    input  logic [1:0]           itask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_re,
    output logic signed [OW-1:0] out_im,
    output logic                 dbz
);

    localparam int CW = $clog2(OW+1);

    typedef enum logic [1:0] {IDLE, CALC, DIVIDE, DONE} state_t;

    state_t state_q, state_d;

    logic signed [W-1:0]  re1_q, re1_d, im1_q, im1_d;
    logic signed [W-1:0]  re2_q, re2_d, im2_q, im2_d;
    logic [1:0]           task_q, task_d;
    logic signed [OW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
    logic                 dbz_q, dbz_d;
    logic [OW-1:0]        num_re_q, num_re_d, num_im_q, num_im_d;
    logic [OW-1:0]        rem_re_q, rem_re_d, rem_im_q, rem_im_d;
    logic [OW-1:0]        den_q, den_d;
    logic                 neg_re_q, neg_re_d, neg_im_q, neg_im_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    // The four cross products are shared: in IDLE they see the live ports
    // (to set up the divider at accept), afterwards the registered operands.
    logic signed [W-1:0]   a_re, a_im, b_re, b_im;
    logic signed [2*W-1:0] p_rr, p_ii, p_ir, p_ri, p_sr, p_si;
    logic signed [OW-1:0]  x_rr, x_ii, x_ir, x_ri, x_sr, x_si;
    logic signed [OW-1:0]  mul_re, mul_im, n_re, n_im, den_s;
    logic signed [OW-1:0]  e_re1, e_im1, e_re2, e_im2;
    logic                  b_zero;

    assign a_re = (state_q == IDLE) ? re1 : re1_q;
    assign a_im = (state_q == IDLE) ? im1 : im1_q;
    assign b_re = (state_q == IDLE) ? re2 : re2_q;
    assign b_im = (state_q == IDLE) ? im2 : im2_q;

    assign p_rr = a_re * b_re;
    assign p_ii = a_im * b_im;
    assign p_ir = a_im * b_re;
    assign p_ri = a_re * b_im;
    assign p_sr = b_re * b_re;
    assign p_si = b_im * b_im;

    assign x_rr = p_rr;
    assign x_ii = p_ii;
    assign x_ir = p_ir;
    assign x_ri = p_ri;
    assign x_sr = p_sr;
    assign x_si = p_si;

    assign mul_re = x_rr - x_ii;
    assign mul_im = x_ir + x_ri;
    assign n_re   = x_rr + x_ii;
    assign n_im   = x_ir - x_ri;
    assign den_s  = x_sr + x_si;
    assign b_zero = (re2 == '0) && (im2 == '0);

    assign e_re1 = re1_q;
    assign e_im1 = im1_q;
    assign e_re2 = re2_q;
    assign e_im2 = im2_q;

    // One restoring step: shift the next numerator bit into the remainder,
    // subtract the divisor when it fits; the quotient bit enters num's LSB
    // so after OW steps num holds the quotient magnitude.
    function automatic logic [2*OW-1:0] div_step(
        input logic [OW-1:0] rem,
        input logic [OW-1:0] num,
        input logic [OW-1:0] den
    );
        logic [OW:0] trial;
        logic        qb;
        trial = {rem, num[OW-1]};
        qb    = (trial >= {1'b0, den});
        if (qb) begin
            trial = trial - {1'b0, den};
        end
        return {trial[OW-1:0], num[OW-2:0], qb};
    endfunction

    function automatic logic [OW-1:0] mag(input logic signed [OW-1:0] x);
        return x[OW-1] ? -x : x;
    endfunction

    always_comb begin
        state_d  = state_q;
        re1_d    = re1_q;
        im1_d    = im1_q;
        re2_d    = re2_q;
        im2_d    = im2_q;
        task_d   = task_q;
        out_re_d = out_re_q;
        out_im_d = out_im_q;
        dbz_d    = dbz_q;
        num_re_d = num_re_q;
        num_im_d = num_im_q;
        rem_re_d = rem_re_q;
        rem_im_d = rem_im_q;
        den_d    = den_q;
        neg_re_d = neg_re_q;
        neg_im_d = neg_im_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    re1_d  = re1;
                    im1_d  = im1;
                    re2_d  = re2;
                    im2_d  = im2;
                    task_d = itask;
                    dbz_d  = 1'b0;
                    if (itask == 2'd3 && !b_zero) begin
                        num_re_d = mag(n_re);
                        num_im_d = mag(n_im);
                        neg_re_d = n_re[OW-1];
                        neg_im_d = n_im[OW-1];
                        den_d    = den_s;
                        rem_re_d = '0;
                        rem_im_d = '0;
                        cnt_d    = '0;
                        state_d  = DIVIDE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                unique case (task_q)
                    2'd0: begin
                        out_re_d = e_re1 + e_re2;
                        out_im_d = e_im1 + e_im2;
                    end
                    2'd1: begin
                        out_re_d = e_re1 - e_re2;
                        out_im_d = e_im1 - e_im2;
                    end
                    2'd2: begin
                        out_re_d = mul_re;
                        out_im_d = mul_im;
                    end
                    default: begin
                        // Only a zero-denominator divide reaches CALC.
                        out_re_d = '0;
                        out_im_d = '0;
                        dbz_d    = 1'b1;
                    end
                endcase
                state_d = DONE;
            end
            DIVIDE: begin
                {rem_re_d, num_re_d} = div_step(rem_re_q, num_re_q, den_q);
                {rem_im_d, num_im_d} = div_step(rem_im_q, num_im_q, den_q);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(OW-1)) begin
                    out_re_d = neg_re_q ? -$signed(num_re_d) : $signed(num_re_d);
                    out_im_d = neg_im_q ? -$signed(num_im_d) : $signed(num_im_d);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            re1_q    <= '0;
            im1_q    <= '0;
            re2_q    <= '0;
            im2_q    <= '0;
            task_q   <= '0;
            out_re_q <= '0;
            out_im_q <= '0;
            dbz_q    <= 1'b0;
            num_re_q <= '0;
            num_im_q <= '0;
            rem_re_q <= '0;
            rem_im_q <= '0;
            den_q    <= '0;
            neg_re_q <= 1'b0;
            neg_im_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            re1_q    <= re1_d;
            im1_q    <= im1_d;
            re2_q    <= re2_d;
            im2_q    <= im2_d;
            task_q   <= task_d;
            out_re_q <= out_re_d;
            out_im_q <= out_im_d;
            dbz_q    <= dbz_d;
            num_re_q <= num_re_d;
            num_im_q <= num_im_d;
            rem_re_q <= rem_re_d;
            rem_im_q <= rem_im_d;
            den_q    <= den_d;
            neg_re_q <= neg_re_d;
            neg_im_q <= neg_im_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign dbz       = dbz_q;

endmodule
